// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry valid/ready pipeline stage with skid register and stall counter
module pipe_stage_skid #(
  parameter int                 DATA_W     = 32,
  parameter logic [DATA_W-1:0]  RESET_DATA = '0,
  parameter logic [DATA_W-1:0]  FLUSH_DATA = '0,
  parameter int                 CNT_W      = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iFlush,
  input  logic              iValidIn,
  input  logic [DATA_W-1:0] iData,
  output logic              oReadyOut,
  output logic              oValidOut,
  output logic [DATA_W-1:0] oData,
  input  logic              iReadyIn,
  input  logic              iClrCount,
  output logic [1:0]        oOccupancy,
  output logic [CNT_W-1:0]  oStallCycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] skid;
  logic [DATA_W-1:0] skid_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = iValidIn & oReadyOut;
  assign out_fire = oValidOut & iReadyIn;

  always_comb begin
    state_nxt = state;
    data_nxt  = oData;
    skid_nxt  = skid;
    if (iFlush) begin
      state_nxt = EMPTY;
      data_nxt  = FLUSH_DATA;
      skid_nxt  = FLUSH_DATA;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            data_nxt  = iData;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            data_nxt = iData;
          end else if (in_fire) begin
            state_nxt = TWO;
            skid_nxt  = iData;
          end else if (out_fire) begin
            // main entry keeps its last payload; it is don't-care while invalid
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_nxt = ONE;
            data_nxt  = skid;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Handshake flags are registered from the next state so upstream ready never sees iReadyIn combinationally.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= EMPTY;
      oData      <= RESET_DATA;
      skid       <= RESET_DATA;
      oReadyOut  <= 1'b1;
      oValidOut  <= 1'b0;
      oOccupancy <= 2'd0;
    end else begin
      state      <= state_nxt;
      oData      <= data_nxt;
      skid       <= skid_nxt;
      oReadyOut  <= (state_nxt != TWO);
      oValidOut  <= (state_nxt != EMPTY);
      oOccupancy <= (state_nxt == TWO) ? 2'd2 : ((state_nxt == ONE) ? 2'd1 : 2'd0);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst || iClrCount) begin
      oStallCycles <= '0;
    end else if (oValidOut && !iReadyIn && (oStallCycles != CNT_MAX)) begin
      oStallCycles <= oStallCycles + 1'b1;
    end
  end

endmodule
